// File: rtl/seq_ripple_borrow_subtractor.sv
// seq_ripple_borrow_subtractor
// Multi-cycle subtractor: diff = in1 - in2 - bin, computed CHUNK bits per
// clock with a registered borrow chain between chunks.
// Valid/ready handshake on the operand side and on the result side.
// Optional macro SUB_SIGNED_OVF_EN adds a registered two's-complement
// overflow flag output 'ovf'.

module seq_ripple_borrow_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSTEP = WIDTH / CHUNK;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             borrow_reg;
    logic [CW-1:0]    cnt;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sub;
    logic             last_step;

    // Slice out the current chunk and subtract it with the running borrow;
    // the extra top bit of the result is the chunk's borrow-out.
    always_comb begin
        base      = 32'(cnt) * 32'(CHUNK);
        a_chunk   = a_reg[base +: CHUNK];
        b_chunk   = b_reg[base +: CHUNK];
        sub       = {1'b0, a_chunk} - {1'b0, b_chunk} - (CHUNK+1)'(borrow_reg);
        last_step = (cnt == CW'(NSTEP - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture and chunk-by-chunk borrow ripple; results hold outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            borrow_reg <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            bout       <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= in1;
                        b_reg      <= in2;
                        borrow_reg <= bin;
                        cnt        <= '0;
                    end
                end
                RUN: begin
                    diff[base +: CHUNK] <= sub[CHUNK-1:0];
                    borrow_reg          <= sub[CHUNK];
                    cnt                 <= cnt + CW'(1);
                    if (last_step) begin
                        bout <= sub[CHUNK];
`ifdef SUB_SIGNED_OVF_EN
                        ovf  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                                (sub[CHUNK-1] != a_reg[WIDTH-1]);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
